// File: rtl/hazard_pkg.sv
// Shared constants for the hazard-report receiver: type codes, report field
// positions and display-state encodings.
package hazard_pkg;

   localparam logic [1:0] HAZ_NONE = 2'b00;
   localparam logic [1:0] HAZ_WAR  = 2'b01;
   localparam logic [1:0] HAZ_RAW  = 2'b10;
   localparam logic [1:0] HAZ_WAW  = 2'b11;

   localparam int TYPE_HI = 7;
   localparam int TYPE_LO = 6;
   localparam int I_HI    = 5;
   localparam int I_LO    = 3;
   localparam int J_HI    = 2;
   localparam int J_LO    = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HOLD = 2'b01,
      ST_GAP  = 2'b10
   } disp_state_t;

endpackage

// File: rtl/hazard_report_rx_if.sv
// Valid/ready hazard-report link; the producer drives valid/data, the
// consumer drives ready.
interface hazard_report_rx_if;

   logic       rep_valid;
   logic [7:0] rep_data;
   logic       rep_ready;

   modport master (output rep_valid, output rep_data, input rep_ready);
   modport slave  (input rep_valid, input rep_data, output rep_ready);

endinterface

// File: rtl/hazard_fifo.sv
// Synchronous FIFO with an occupancy counter; full/empty come straight from
// the registered count so they never depend on the current push/pop.
module hazard_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_LVL);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage is left unreset; only the pointers and count define contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hazard_report_rx.sv
// Hazard-report consumer: filters incoming reports, queues them and shows each
// on led for a hold time followed by a blank gap. HAZARD_COUNT_EN adds per-type counters.
module hazard_report_rx
   import hazard_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 5_000_000
`ifdef HAZARD_COUNT_EN
   ,
   parameter int CNT_W       = 8
`endif
) (
   input  logic               clk,
   input  logic               rst,
   hazard_report_rx_if.slave  rep,
   output logic [7:0]         led,
   output logic               disp_busy,
   output logic               fmt_err
`ifdef HAZARD_COUNT_EN
   ,
   output logic [CNT_W-1:0]   raw_cnt,
   output logic [CNT_W-1:0]   war_cnt,
   output logic [CNT_W-1:0]   waw_cnt
`endif
);

   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

   logic [1:0]  rtype;
   logic [2:0]  ri;
   logic [2:0]  rj;
   logic        xfer;
   logic        push;
   logic        bad;
   logic        pop;
   logic        full;
   logic        empty;
   logic [7:0]  dout;

   disp_state_t state, state_n;
   logic [TW-1:0] cnt, cnt_n;
   logic [7:0]    led_n;

   assign rtype = rep.rep_data[TYPE_HI:TYPE_LO];
   assign ri    = rep.rep_data[I_HI:I_LO];
   assign rj    = rep.rep_data[J_HI:J_LO];

   assign rep.rep_ready = !full;
   assign xfer = rep.rep_valid && !full;
   assign push = xfer && (rtype != HAZ_NONE) && (ri < rj);
   assign bad  = xfer && (rtype != HAZ_NONE) && (ri >= rj);

   hazard_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (rep.rep_data),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fmt_err <= 1'b0;
      end else if (bad) begin
         fmt_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         led   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         led   <= led_n;
      end
   end

   // The FIFO is popped only from IDLE after checking empty, so an empty pop cannot occur.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      led_n   = led;
      pop     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               led_n   = dout;
               cnt_n   = HOLD_LOAD;
               state_n = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt == '0) begin
               led_n   = '0;
               cnt_n   = GAP_LOAD;
               state_n = ST_GAP;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt == '0) begin
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            led_n   = '0;
            state_n = ST_IDLE;
         end
      endcase
   end

   assign disp_busy = (state != ST_IDLE);

`ifdef HAZARD_COUNT_EN
   // Counters track stored reports only and stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         raw_cnt <= '0;
         war_cnt <= '0;
         waw_cnt <= '0;
      end else if (push) begin
         case (rtype)
            HAZ_RAW: if (raw_cnt != '1) raw_cnt <= raw_cnt + 1'b1;
            HAZ_WAR: if (war_cnt != '1) war_cnt <= war_cnt + 1'b1;
            HAZ_WAW: if (waw_cnt != '1) waw_cnt <= waw_cnt + 1'b1;
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_hazard_report_rx.sv
// Bench for hazard_report_rx: directed scenarios plus random traffic, all
// compared against a schedule-based reference model of queue and display timeline.
module tb_hazard_report_rx;

   localparam int DEPTH = 4;
   localparam int HOLD  = 4;
   localparam int GAP   = 2;
`ifdef HAZARD_COUNT_EN
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`else
   localparam int CNT_MAX = 255;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] led;
   logic       disp_busy;
   logic       fmt_err;
`ifdef HAZARD_COUNT_EN
   logic [CNT_W-1:0] raw_cnt, war_cnt, waw_cnt;
`endif

   hazard_report_rx_if rep_if ();

   hazard_report_rx #(
      .DEPTH       (DEPTH),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP)
`ifdef HAZARD_COUNT_EN
      ,
      .CNT_W       (CNT_W)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rep       (rep_if),
      .led       (led),
      .disp_busy (disp_busy),
      .fmt_err   (fmt_err)
`ifdef HAZARD_COUNT_EN
      ,
      .raw_cnt   (raw_cnt),
      .war_cnt   (war_cnt),
      .waw_cnt   (waw_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of stored reports plus the edge at which the
   // current report went on display and the earliest edge the next may start.
   int         cyc = 0;
   logic [7:0] q[$];
   int         disp_start = -100;
   logic [7:0] disp_val = 8'h00;
   int         next_pop = 0;
   bit         m_fmt = 1'b0;
   int         m_raw = 0, m_war = 0, m_waw = 0;

   function automatic int sat(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   function automatic logic [7:0] expLed();
      return (cyc >= disp_start && cyc < disp_start + HOLD) ? disp_val : 8'h00;
   endfunction

   function automatic bit expBusy();
      return (cyc >= disp_start && cyc < disp_start + HOLD + GAP);
   endfunction

   function automatic logic [7:0] randHaz();
      logic [1:0] t;
      int         i, j;
      t = 2'($urandom_range(1, 3));
      j = $urandom_range(1, 7);
      i = $urandom_range(0, j - 1);
      return {t, 3'(i), 3'(j)};
   endfunction

   task automatic modelEdge(input bit v, input logic [7:0] d, input bit r, output bit took);
      bit can_take;
      cyc++;
      took = 1'b0;
      if (r) begin
         q.delete();
         disp_start = -100;
         next_pop   = cyc + 1;
         m_fmt      = 1'b0;
         m_raw = 0; m_war = 0; m_waw = 0;
      end else begin
         can_take = (q.size() < DEPTH);
         if (q.size() > 0 && cyc >= next_pop) begin
            disp_val   = q.pop_front();
            disp_start = cyc;
            next_pop   = cyc + HOLD + GAP + 1;
         end
         if (v && can_take) begin
            took = 1'b1;
            if (d[7:6] != 2'b00) begin
               if (d[5:3] < d[2:0]) begin
                  q.push_back(d);
                  case (d[7:6])
                     2'b10:   m_raw = sat(m_raw);
                     2'b01:   m_war = sat(m_war);
                     default: m_waw = sat(m_waw);
                  endcase
               end else begin
                  m_fmt = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r, output bit took);
      rep_if.rep_valid = v;
      rep_if.rep_data  = d;
      rst              = r;
      @(posedge clk);
      modelEdge(v, d, r, took);
      @(negedge clk);
      checkOutput("led", led, expLed());
      checkOutput("rep_ready", rep_if.rep_ready, (q.size() < DEPTH));
      checkOutput("disp_busy", disp_busy, expBusy());
      checkOutput("fmt_err", fmt_err, m_fmt);
`ifdef HAZARD_COUNT_EN
      checkOutput("raw_cnt", raw_cnt, m_raw);
      checkOutput("war_cnt", war_cnt, m_war);
      checkOutput("waw_cnt", waw_cnt, m_waw);
`endif
   endtask

   bit         took;
   logic [7:0] burst[5];
   logic [7:0] shown[$];
   logic [7:0] prev_led;
   bit         saw_full;
   int         idx;
   int         n;
   bit         v;

   initial begin
      rep_if.rep_valid = 1'b0;
      rep_if.rep_data  = 8'h00;
      rst              = 1'b1;

      applyStimulus(0, 8'h00, 1, took);
      applyStimulus(0, 8'h00, 1, took);
      checkOutput("reset_led", led, 8'h00);
      checkOutput("reset_ready", rep_if.rep_ready, 1);
      checkOutput("reset_busy", disp_busy, 0);
      checkOutput("reset_fmt", fmt_err, 0);

      // Single report: on display the edge after it is stored, for HOLD cycles.
      applyStimulus(1, 8'b10_000_001, 0, took);
      for (int k = 0; k < HOLD; k++) begin
         applyStimulus(0, 8'h00, 0, took);
         checkOutput("t1_led_hold", led, 8'h81);
         checkOutput("t1_busy_hold", disp_busy, 1);
      end
      for (int k = 0; k <= GAP; k++) begin
         applyStimulus(0, 8'h00, 0, took);
         checkOutput("t1_led_gap", led, 8'h00);
         checkOutput("t1_busy_gap", disp_busy, (k < GAP));
      end

      // Burst with valid held: back-pressure, then strict display order.
      burst[0] = 8'h81; burst[1] = 8'hCA; burst[2] = 8'h53;
      burst[3] = 8'h9C; burst[4] = 8'hE5;
      idx = 0; n = 0; saw_full = 0; prev_led = 8'h00;
      shown.delete();
      while (idx < 5 && n < 100) begin
         applyStimulus(1, burst[idx], 0, took);
         if (took) idx++;
         if (!rep_if.rep_ready) saw_full = 1;
         if (prev_led == 8'h00 && led != 8'h00) shown.push_back(led);
         prev_led = led;
         n++;
      end
      checkOutput("t2_all_taken", idx, 5);
      checkOutput("t2_ready_dropped", saw_full, 1);
      for (int k = 0; k < 50; k++) begin
         applyStimulus(0, 8'h00, 0, took);
         if (prev_led == 8'h00 && led != 8'h00) shown.push_back(led);
         prev_led = led;
      end
      checkOutput("t2_shown_count", shown.size(), 5);
      for (int k = 0; k < 5 && k < shown.size(); k++) begin
         checkOutput("t2_order", shown[k], burst[k]);
      end

      // NONE report is silently dropped; i>=j raises a sticky error.
      applyStimulus(1, 8'b00_001_010, 0, took);
      applyStimulus(0, 8'h00, 0, took);
      checkOutput("t3_none_no_err", fmt_err, 0);
      checkOutput("t3_none_no_disp", led, 8'h00);
      applyStimulus(1, 8'b01_011_010, 0, took);
      for (int k = 0; k < 10; k++) applyStimulus(0, 8'h00, 0, took);
      checkOutput("t3_fmt_sticky", fmt_err, 1);
      checkOutput("t3_bad_no_disp", led, 8'h00);
      applyStimulus(0, 8'h00, 1, took);
      checkOutput("t3_fmt_cleared", fmt_err, 0);

      // Reset mid-hold with reports still queued.
      applyStimulus(1, 8'h81, 0, took);
      applyStimulus(1, 8'hCA, 0, took);
      applyStimulus(1, 8'h53, 0, took);
      n = 0;
      while (led == 8'h00 && n < 20) begin
         applyStimulus(0, 8'h00, 0, took);
         n++;
      end
      checkOutput("t4_shown_before_rst", (led != 8'h00), 1);
      applyStimulus(0, 8'h00, 0, took);
      applyStimulus(0, 8'h00, 1, took);
      checkOutput("t4_led_after_rst", led, 8'h00);
      checkOutput("t4_ready_after_rst", rep_if.rep_ready, 1);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(0, 8'h00, 0, took);
         checkOutput("t4_no_display", led, 8'h00);
      end

`ifdef HAZARD_COUNT_EN
      // Saturating counters.
      for (int k = 0; k < 5; k++) applyStimulus(1, 8'hCA, 0, took);
      checkOutput("t5_waw_sat", waw_cnt, 3);
      checkOutput("t5_raw_zero", raw_cnt, 0);
      checkOutput("t5_war_zero", war_cnt, 0);
      for (int k = 0; k < 40; k++) applyStimulus(0, 8'h00, 0, took);
      applyStimulus(0, 8'h00, 1, took);
`endif

      // Hold the FIFO at DEPTH-1 and push on every pop edge for several laps.
      for (int k = 0; k < 110; k++) begin
         v = (q.size() < DEPTH - 1) ||
             (q.size() == DEPTH - 1 && cyc + 1 >= next_pop);
         applyStimulus(v, randHaz(), 0, took);
         if (k > 5) checkOutput("t6_ready_steady", rep_if.rep_ready, 1);
      end
      for (int k = 0; k < 40; k++) applyStimulus(0, 8'h00, 0, took);

      // Random traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         applyStimulus(bit'($urandom_range(0, 1)), 8'($urandom),
                       ($urandom_range(0, 199) == 0), took);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
